// File: rtl/regfile_wb_arbiter_if.sv
// Requester-side handshake bundle for the register-file write-back arbiter.
// The two requesters are A (ALU result) and M (load data).
interface regfile_wb_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_reg;
    logic [DW-1:0] a_data;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_reg;
    logic [DW-1:0] m_data;

    modport master (
        output a_valid, a_reg, a_data, m_valid, m_reg, m_data,
        input  a_ready, m_ready
    );

    modport slave (
        input  a_valid, a_reg, a_data, m_valid, m_reg, m_data,
        output a_ready, m_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs load) driving the register file's single write port.
// The optional decode bypass is compiled in with `define REGFILE_WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned CNT_W   = 16,
    parameter bit          M_FIRST = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    regfile_wb_arbiter_if.slave  req,
    output logic                 RegWrite,
    output logic [AW-1:0]        w_reg,
    output logic [DW-1:0]        w_data,
    output logic [CNT_W-1:0]     conflict_cnt,
    input  logic [AW-1:0]        RegRead_1,
    input  logic [AW-1:0]        RegRead_2,
    output logic                 fwd1_hit,
    output logic                 fwd2_hit,
    output logic [DW-1:0]        fwd1_data,
    output logic [DW-1:0]        fwd2_data
);
    typedef enum logic {PRI_A = 1'b0, PRI_M = 1'b1} prio_e;
    localparam prio_e PRIO_RST = prio_e'(M_FIRST);

    prio_e            prio_q, prio_d;
    logic             we_q, we_d;
    logic [AW-1:0]    wreg_q, wreg_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             grant_a_c, grant_m_c, both_c;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            prio_q  <= PRIO_RST;
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            prio_q  <= prio_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grant, priority hand-off and output-register next state.
    always_comb begin
        prio_d    = prio_q;
        we_d      = 1'b0;
        wreg_d    = wreg_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        grant_a_c = 1'b0;
        grant_m_c = 1'b0;
        both_c    = req.a_valid && req.m_valid;

        // Nothing is accepted while reset is held, so readys stay low then.
        if (!RESET) begin
            grant_a_c = req.a_valid && (!req.m_valid || prio_q == PRI_A);
            grant_m_c = req.m_valid && (!req.a_valid || prio_q == PRI_M);
        end

        // R0 writes finish the handshake but never raise RegWrite.
        if (grant_a_c) begin
            we_d    = (req.a_reg != '0);
            wreg_d  = req.a_reg;
            wdata_d = req.a_data;
        end else if (grant_m_c) begin
            we_d    = (req.m_reg != '0);
            wreg_d  = req.m_reg;
            wdata_d = req.m_data;
        end

        if (both_c) begin
            prio_d = (prio_q == PRI_M) ? PRI_A : PRI_M;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign req.a_ready  = grant_a_c;
    assign req.m_ready  = grant_m_c;
    assign RegWrite     = we_q;
    assign w_reg        = wreg_q;
    assign w_data       = wdata_q;
    assign conflict_cnt = cnt_q;

`ifdef REGFILE_WB_FWD_EN
    assign fwd1_hit  = we_q && (wreg_q == RegRead_1);
    assign fwd2_hit  = we_q && (wreg_q == RegRead_2);
    assign fwd1_data = fwd1_hit ? wdata_q : '0;
    assign fwd2_data = fwd2_hit ? wdata_q : '0;
`else
    logic unused_rd_c;
    assign unused_rd_c = ^{RegRead_1, RegRead_2};
    assign fwd1_hit    = 1'b0;
    assign fwd2_hit    = 1'b0;
    assign fwd1_data   = '0;
    assign fwd2_data   = '0;
`endif
endmodule
